// File: rtl/wsb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wsb_pkg
// Description : Shared types and constants for the window shift buffer.
//               Provides the FSM state enum, the default geometry and the
//               helper that maps a (lane, row) pixel to its out_win offset.
// Revision    : 1.0 - initial release
// ============================================================================
package wsb_pkg;

    typedef enum logic [1:0] {
        WSB_FILL    = 2'd0,
        WSB_PRESENT = 2'd1,
        WSB_STALE   = 2'd2
    } wsb_state_t;

    localparam int WSB_PIX_W = 8;
    localparam int WSB_LANES = 8;
    localparam int WSB_DEPTH = 15;

    // Bit offset of pixel (lane, row) inside the transposed output window.
    function automatic int wsb_idx(input int lane, input int row, input int depth,
                                   input int pix_w = WSB_PIX_W);
        return (lane * depth + row) * pix_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wsb_row_reg.sv
`default_nettype none
// ============================================================================
// Module      : wsb_row_reg
// Description : One buffered row. Asynchronous active-low reset, synchronous
//               clear (wins over load) and a load enable.
// Revision    : 1.0 - initial release
// ============================================================================
module wsb_row_reg
    import wsb_pkg::*;
#(
    parameter int WIDTH = WSB_LANES * WSB_PIX_W
) (
    input  logic             clock,
    input  logic             reset_L,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Next row value: clear dominates, otherwise load or hold.
    always_comb begin
        data_d = data_q;
        if (clear) begin
            data_d = '0;
        end else if (load) begin
            data_d = d;
        end
    end

    // Row storage.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule
`default_nettype wire

// File: rtl/window_shift_buffer.sv
`default_nettype none
// ============================================================================
// Module      : window_shift_buffer
// Description : Holds the last DEPTH rows of LANES pixels and presents them
//               column-transposed as a filter window, with valid/ready flow
//               control, fill tracking and synchronous flush.
//               Optional build macro WSB_EDGE_PAD_EN: the first row after an
//               empty buffer is replicated into rows 0..PAD_ROWS.
// Revision    : 1.0 - initial release
// ============================================================================
module window_shift_buffer
    import wsb_pkg::*;
#(
    parameter int PIX_W    = WSB_PIX_W,
    parameter int LANES    = WSB_LANES,
    parameter int DEPTH    = WSB_DEPTH,
    parameter int PAD_ROWS = 3
) (
    input  logic                           clock,
    input  logic                           reset_L,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [LANES*PIX_W-1:0]         in_row,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [LANES*DEPTH*PIX_W-1:0]   out_win,
    output logic [$clog2(DEPTH+1)-1:0]     fill_cnt
);

    localparam int ROW_W = LANES * PIX_W;
    localparam int CNT_W = $clog2(DEPTH + 1);
    // Clamp so an out-of-range PAD_ROWS can never index past the last row.
    localparam int PAD_N = (PAD_ROWS < DEPTH) ? PAD_ROWS : DEPTH - 1;
`ifdef WSB_EDGE_PAD_EN
    localparam int FIRST_INC = PAD_N + 1;
`else
    localparam int FIRST_INC = 1;
`endif

    logic [ROW_W-1:0] row_q [DEPTH];
    logic [ROW_W-1:0] row_d [DEPTH];

    wsb_state_t       state_q, state_d;
    logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;
    logic             out_valid_q, out_valid_d;
    logic             accept;
    logic             pad_load;

    // Only a presented window can hold off the producer.
    assign in_ready = (state_q != WSB_PRESENT) | out_ready;
    assign accept   = in_valid & in_ready;

`ifdef WSB_EDGE_PAD_EN
    assign pad_load = accept & (fill_cnt_q == '0);
`else
    assign pad_load = 1'b0;
`endif

    // Shift chain: row 0 takes the new row, deeper rows take their neighbour,
    // except the top-edge rows that are filled with the first row on padding.
    for (genvar i = 0; i < DEPTH; i++) begin : g_row
        if (i == 0) begin : g_head
            assign row_d[i] = in_row;
        end else if (i <= PAD_N) begin : g_pad
            assign row_d[i] = pad_load ? in_row : row_q[i-1];
        end else begin : g_shift
            assign row_d[i] = row_q[i-1];
        end

        wsb_row_reg #(
            .WIDTH (ROW_W)
        ) u_row (
            .clock   (clock),
            .reset_L (reset_L),
            .clear   (flush),
            .load    (accept),
            .d       (row_d[i]),
            .q       (row_q[i])
        );
    end

    // Transpose: pure wiring from row-major storage to lane-major window.
    for (genvar j = 0; j < LANES; j++) begin : g_lane
        for (genvar i = 0; i < DEPTH; i++) begin : g_win
            assign out_win[wsb_idx(j, i, DEPTH, PIX_W) +: PIX_W] = row_q[i][j*PIX_W +: PIX_W];
        end
    end

    // Next-state logic for fill tracking and window presentation.
    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        if (flush) begin
            state_d    = WSB_FILL;
            fill_cnt_d = '0;
        end else begin
            case (state_q)
                WSB_FILL: begin
                    if (accept) begin
                        fill_cnt_d = pad_load ? CNT_W'(FIRST_INC) : fill_cnt_q + 1'b1;
                        if (fill_cnt_d == CNT_W'(DEPTH)) begin
                            state_d = WSB_PRESENT;
                        end
                    end
                end
                WSB_PRESENT: begin
                    if (out_ready) begin
                        state_d = accept ? WSB_PRESENT : WSB_STALE;
                    end
                end
                WSB_STALE: begin
                    if (accept) begin
                        state_d = WSB_PRESENT;
                    end
                end
                default: begin
                    state_d    = WSB_FILL;
                    fill_cnt_d = '0;
                end
            endcase
        end
        out_valid_d = (state_d == WSB_PRESENT);
    end

    // Control state and registered valid.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state_q     <= WSB_FILL;
            fill_cnt_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign fill_cnt  = fill_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_window_shift_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_window_shift_buffer
// Description : Self-checking bench for window_shift_buffer: directed
//               scenarios plus randomized traffic against a row-queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_window_shift_buffer;

    localparam int PIX_W    = 8;
    localparam int LANES    = 8;
    localparam int DEPTH    = 15;
    localparam int PAD_ROWS = 3;
    localparam int ROW_W    = LANES * PIX_W;
    localparam int CNT_W    = $clog2(DEPTH + 1);

    logic                         clock = 1'b0;
    logic                         reset_L = 1'b0;
    logic                         flush = 1'b0;
    logic                         in_valid = 1'b0;
    logic                         out_ready = 1'b0;
    logic [ROW_W-1:0]             in_row = '0;
    logic                         in_ready;
    logic                         out_valid;
    logic [LANES*DEPTH*PIX_W-1:0] out_win;
    logic [CNT_W-1:0]             fill_cnt;

    window_shift_buffer #(
        .PIX_W    (PIX_W),
        .LANES    (LANES),
        .DEPTH    (DEPTH),
        .PAD_ROWS (PAD_ROWS)
    ) dut (
        .clock     (clock),
        .reset_L   (reset_L),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_row    (in_row),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_win   (out_win),
        .fill_cnt  (fill_cnt)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: rows[0] newest, fill count, and "window pending" flag.
    logic [ROW_W-1:0] m_rows [DEPTH];
    int               m_fill;
    bit               m_pend;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Gather row i back out of the window using the documented bit layout.
    function automatic logic [ROW_W-1:0] win_row(input int i);
        logic [ROW_W-1:0] r;
        r = '0;
        for (int j = 0; j < LANES; j++) begin
            r[j*PIX_W +: PIX_W] = out_win[(j*DEPTH+i)*PIX_W +: PIX_W];
        end
        return r;
    endfunction

    function automatic logic [7:0] pix(input int lane, input int row);
        return out_win[(lane*DEPTH+row)*PIX_W +: PIX_W];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_rows[i] = '0;
        m_fill = 0;
        m_pend = 1'b0;
    endtask

    task automatic check_all(input string where);
        check({where, ".in_ready"}, 64'(in_ready), 64'(!m_pend || out_ready));
        check({where, ".out_valid"}, 64'(out_valid), 64'(m_pend));
        check({where, ".fill_cnt"}, 64'(fill_cnt), 64'(m_fill));
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("%s.row%0d", where, i), win_row(i), m_rows[i]);
        end
    endtask

    // Apply one clock edge's worth of the documented rules to the model.
    task automatic model_edge();
        bit acc;
        acc = in_valid && (!m_pend || out_ready);
        if (flush) begin
            model_reset();
        end else if (acc) begin
`ifdef WSB_EDGE_PAD_EN
            if (m_fill == 0) begin
                for (int i = 0; i <= PAD_ROWS; i++) m_rows[i] = in_row;
                m_fill = PAD_ROWS + 1;
            end else
`endif
            begin
                for (int i = DEPTH - 1; i > 0; i--) m_rows[i] = m_rows[i-1];
                m_rows[0] = in_row;
                m_fill = (m_fill + 1 > DEPTH) ? DEPTH : m_fill + 1;
            end
            if (m_fill == DEPTH) m_pend = 1'b1;
        end else if (m_pend && out_ready) begin
            m_pend = 1'b0;
        end
    endtask

    // Drive one cycle from a falling edge, check, advance model at the rising edge.
    task automatic step(input bit v, input logic [ROW_W-1:0] row, input bit rdy, input bit fl);
        in_valid  = v;
        in_row    = row;
        out_ready = rdy;
        flush     = fl;
        #1;
        check_all("step");
        @(posedge clock);
        model_edge();
        @(negedge clock);
    endtask

    logic [ROW_W-1:0] saved [DEPTH];
    logic [ROW_W-1:0] tmp;

    initial begin
        model_reset();
        @(negedge clock);
        #1;
        check_all("reset");
        check("reset.win", 64'(|out_win), 64'd0);
        reset_L = 1'b1;
        @(negedge clock);

`ifndef WSB_EDGE_PAD_EN
        // Fill with rows whose every lane equals the row number.
        for (int r = 1; r <= DEPTH; r++) step(1'b1, {LANES{8'(r)}}, 1'b0, 1'b0);
        #1;
        check("fill.out_valid", 64'(out_valid), 64'd1);
        check("fill.l3r0", 64'(pix(3, 0)), 64'd15);
        check("fill.l3r14", 64'(pix(3, 14)), 64'd1);
        check("fill.cnt", 64'(fill_cnt), 64'd15);
`else
        for (int r = 1; r <= DEPTH; r++) step(1'b1, {LANES{8'(r)}}, 1'b0, 1'b0);
`endif

        // Back-pressure: window must hold while the consumer stalls.
        for (int i = 0; i < DEPTH; i++) saved[i] = win_row(i);
        for (int k = 0; k < 5; k++) step(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
        #1;
        check("bp.in_ready", 64'(in_ready), 64'd0);
        for (int i = 0; i < DEPTH; i++) check($sformatf("bp.hold%0d", i), win_row(i), saved[i]);
        tmp = {$urandom, $urandom};
        step(1'b1, tmp, 1'b1, 1'b0);
        #1;
        check("bp.release_valid", 64'(out_valid), 64'd1);
        check("bp.release_row0", win_row(0), tmp);
        check("bp.release_row1", win_row(1), saved[0]);

        // Consume without new data, then refresh with one accept.
        step(1'b0, '0, 1'b1, 1'b0);
        #1;
        check("stale.out_valid", 64'(out_valid), 64'd0);
        check("stale.in_ready", 64'(in_ready), 64'd1);
        step(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
        #1;
        check("stale.refresh", 64'(out_valid), 64'd1);

        // Flush at fill 9 together with an accept and a consume.
        step(1'b0, '0, 1'b0, 1'b1);
        for (int k = 0; k < 9; k++) step(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
        step(1'b1, {$urandom, $urandom}, 1'b1, 1'b1);
        #1;
        check("flush.cnt", 64'(fill_cnt), 64'd0);
        check("flush.win", 64'(|out_win), 64'd0);
        check("flush.out_valid", 64'(out_valid), 64'd0);

        // Asynchronous reset in the middle of a cycle while presenting.
        for (int k = 0; k < DEPTH; k++) step(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
        #1;
        check("arst.pre_valid", 64'(out_valid), 64'(m_pend));
        #2;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        reset_L   = 1'b0;
        #1;
        check("arst.out_valid", 64'(out_valid), 64'd0);
        check("arst.cnt", 64'(fill_cnt), 64'd0);
        check("arst.win", 64'(|out_win), 64'd0);
        check("arst.in_ready", 64'(in_ready), 64'd1);
        model_reset();
        @(negedge clock);
        reset_L  = 1'b1;
        in_valid = 1'b0;

`ifdef WSB_EDGE_PAD_EN
        // Top-edge padding replicates the first row.
        step(1'b1, {LANES{8'hAA}}, 1'b0, 1'b0);
        #1;
        for (int i = 0; i <= PAD_ROWS; i++) check($sformatf("pad.row%0d", i), win_row(i), {LANES{8'hAA}});
        check("pad.cnt", 64'(fill_cnt), 64'(PAD_ROWS + 1));
        for (int k = 0; k < DEPTH - PAD_ROWS - 1; k++) step(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
        #1;
        check("pad.out_valid", 64'(out_valid), 64'd1);
`endif

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 9) < 7, {$urandom, $urandom},
                 $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
